// File: rtl/fb_addr_arbiter_512_if.sv
// Address-channel bundle shared by the frame-buffer write engine, the
// frame-buffer read engine, the DDR controller port and the arbiter.
// master: arbiter view. slave: surrounding engines / controller view.
interface fb_addr_arbiter_512_if;
   logic        wr_avalid;
   logic [31:0] wr_addr;
   logic        wr_aready;
   logic        wr_last_beat;
   logic        rd_avalid;
   logic [31:0] rd_addr;
   logic        rd_aready;
   logic        rd_last_beat;
   logic        ddr_avalid;
   logic        ddr_aready;
   logic [31:0] ddr_aaddr;
   logic        ddr_atype;
   logic [7:0]  ddr_alen;
   logic [2:0]  wr_outstanding;
   logic [2:0]  rd_outstanding;
   logic        cnt_err;

   modport master (
      input  wr_avalid, wr_addr, wr_last_beat,
      input  rd_avalid, rd_addr, rd_last_beat,
      input  ddr_aready,
      output wr_aready, rd_aready,
      output ddr_avalid, ddr_aaddr, ddr_atype, ddr_alen,
      output wr_outstanding, rd_outstanding, cnt_err
   );

   modport slave (
      output wr_avalid, wr_addr, wr_last_beat,
      output rd_avalid, rd_addr, rd_last_beat,
      output ddr_aready,
      input  wr_aready, rd_aready,
      input  ddr_avalid, ddr_aaddr, ddr_atype, ddr_alen,
      input  wr_outstanding, rd_outstanding, cnt_err
   );
endinterface

// File: rtl/fb_addr_arbiter_512.sv
// Arbitrates the single DDR address channel between the frame-buffer write
// and read engines. One burst address in flight at a time; reads win
// contention up to MAX_RD_STREAK times in a row, then a write is forced.
// Outstanding bursts per direction are bounded by data-completion counters.
module fb_addr_arbiter_512 #(
   parameter int BURST_LEN     = 32,
   parameter int MAX_OUT_WR    = 2,
   parameter int MAX_OUT_RD    = 4,
   parameter int MAX_RD_STREAK = 3
) (
   input  logic                          axi_clk,
   input  logic                          rst,
   fb_addr_arbiter_512_if.master         bus
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t      state_q,      state_d;
   logic        avalid_q,     avalid_d;
   logic [31:0] aaddr_q,      aaddr_d;
   logic        atype_q,      atype_d;
   logic        wr_aready_q,  wr_aready_d;
   logic        rd_aready_q,  rd_aready_d;
   logic [2:0]  wr_out_q,     wr_out_d;
   logic [2:0]  rd_out_q,     rd_out_d;
   logic [3:0]  rd_streak_q,  rd_streak_d;
   logic        cnt_err_q,    cnt_err_d;

   logic        wr_elig_s;
   logic        rd_elig_s;
   logic        grant_wr_s;
   logic        grant_rd_s;

   // Next outstanding count: a grant adds one, a completion removes one,
   // a completion with nothing outstanding is dropped (flagged elsewhere).
   function automatic logic [2:0] cnt_next(input logic [2:0] cnt,
                                           input logic       inc,
                                           input logic       dec);
      logic dec_ok;
      logic [2:0] res;
      dec_ok = dec & (cnt != 3'd0);
      if (inc && !dec_ok) begin
         res = cnt + 3'd1;
      end else if (!inc && dec_ok) begin
         res = cnt - 3'd1;
      end else begin
         res = cnt;
      end
      return res;
   endfunction

   // Request eligibility: a direction at its outstanding limit waits.
   always_comb begin
      wr_elig_s = bus.wr_avalid & (wr_out_q < 3'(MAX_OUT_WR));
      rd_elig_s = bus.rd_avalid & (rd_out_q < 3'(MAX_OUT_RD));
   end

   // Arbitration FSM: selection in IDLE, hold the address in ISSUE.
   always_comb begin
      state_d     = state_q;
      avalid_d    = avalid_q;
      aaddr_d     = aaddr_q;
      atype_d     = atype_q;
      rd_streak_d = rd_streak_q;
      wr_aready_d = 1'b0;
      rd_aready_d = 1'b0;
      grant_wr_s  = 1'b0;
      grant_rd_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rd_elig_s && wr_elig_s) begin
               if (rd_streak_q < 4'(MAX_RD_STREAK)) begin
                  grant_rd_s  = 1'b1;
                  rd_streak_d = rd_streak_q + 4'd1;
               end else begin
                  grant_wr_s  = 1'b1;
                  rd_streak_d = 4'd0;
               end
            end else if (rd_elig_s) begin
               // No competing write: streak is left where it is.
               grant_rd_s = 1'b1;
            end else if (wr_elig_s) begin
               grant_wr_s  = 1'b1;
               rd_streak_d = 4'd0;
            end else begin
               state_d = ST_IDLE;
            end

            if (grant_rd_s) begin
               aaddr_d     = bus.rd_addr;
               atype_d     = 1'b0;
               avalid_d    = 1'b1;
               rd_aready_d = 1'b1;
               state_d     = ST_ISSUE;
            end else if (grant_wr_s) begin
               aaddr_d     = bus.wr_addr;
               atype_d     = 1'b1;
               avalid_d    = 1'b1;
               wr_aready_d = 1'b1;
               state_d     = ST_ISSUE;
            end else begin
               avalid_d = 1'b0;
            end
         end
         ST_ISSUE: begin
            if (bus.ddr_aready) begin
               avalid_d = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               avalid_d = 1'b1;
            end
         end
         default: begin
            avalid_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // Outstanding-burst counters and sticky underflow flag.
   always_comb begin
      wr_out_d  = cnt_next(wr_out_q, grant_wr_s, bus.wr_last_beat);
      rd_out_d  = cnt_next(rd_out_q, grant_rd_s, bus.rd_last_beat);
      cnt_err_d = cnt_err_q
                | (bus.wr_last_beat & (wr_out_q == 3'd0))
                | (bus.rd_last_beat & (rd_out_q == 3'd0));
   end

   // State and output registers; reset drops the address valid immediately.
   always_ff @(posedge axi_clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         avalid_q    <= 1'b0;
         aaddr_q     <= 32'd0;
         atype_q     <= 1'b0;
         wr_aready_q <= 1'b0;
         rd_aready_q <= 1'b0;
         wr_out_q    <= 3'd0;
         rd_out_q    <= 3'd0;
         rd_streak_q <= 4'd0;
         cnt_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         avalid_q    <= avalid_d;
         aaddr_q     <= aaddr_d;
         atype_q     <= atype_d;
         wr_aready_q <= wr_aready_d;
         rd_aready_q <= rd_aready_d;
         wr_out_q    <= wr_out_d;
         rd_out_q    <= rd_out_d;
         rd_streak_q <= rd_streak_d;
         cnt_err_q   <= cnt_err_d;
      end
   end

   assign bus.ddr_avalid     = avalid_q;
   assign bus.ddr_aaddr      = aaddr_q;
   assign bus.ddr_atype      = atype_q;
   assign bus.ddr_alen       = 8'(BURST_LEN - 1);
   assign bus.wr_aready      = wr_aready_q;
   assign bus.rd_aready      = rd_aready_q;
   assign bus.wr_outstanding = wr_out_q;
   assign bus.rd_outstanding = rd_out_q;
   assign bus.cnt_err        = cnt_err_q;

endmodule

// File: tb/tb_fb_addr_arbiter_512.sv
// Directed bench for fb_addr_arbiter_512: a per-cycle vector table for
// single-write latency, write-full back-off and counter corner cases, plus
// hand-written sequences for contention order, backpressure and async reset.
module tb_fb_addr_arbiter_512;

   logic clk;
   logic rst;

   fb_addr_arbiter_512_if bus();

   fb_addr_arbiter_512 #(
      .BURST_LEN     (32),
      .MAX_OUT_WR    (2),
      .MAX_OUT_RD    (4),
      .MAX_RD_STREAK (3)
   ) dut (
      .axi_clk (clk),
      .rst     (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic        wv;
      logic [31:0] wa;
      logic        wl;
      logic        rv;
      logic [31:0] ra;
      logic        rl;
      logic        dr;
      logic        e_av;
      logic        e_at;
      logic [31:0] e_aa;
      logic        e_wr;
      logic        e_rr;
      logic [2:0]  e_wo;
      logic [2:0]  e_ro;
      logic        e_err;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   logic lb_wr [64];
   logic lb_rd [64];
   logic exp_w [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [42:0] outs();
      return {bus.ddr_avalid, bus.ddr_atype, bus.ddr_aaddr, bus.wr_aready, bus.rd_aready,
              bus.wr_outstanding, bus.rd_outstanding, bus.cnt_err};
   endfunction

   task automatic idle_inputs();
      bus.wr_avalid    = 1'b0;
      bus.wr_addr      = 32'd0;
      bus.wr_last_beat = 1'b0;
      bus.rd_avalid    = 1'b0;
      bus.rd_addr      = 32'd0;
      bus.rd_last_beat = 1'b0;
      bus.ddr_aready   = 1'b0;
   endtask

   // Ends on a negedge with rst released.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic vec_t mk(input logic wv, input logic [31:0] wa, input logic wl,
                               input logic rv, input logic [31:0] ra, input logic rl,
                               input logic dr,
                               input logic av, input logic at, input logic [31:0] aa,
                               input logic wr, input logic rr,
                               input logic [2:0] wo, input logic [2:0] ro, input logic er);
      vec_t v;
      v.wv = wv; v.wa = wa; v.wl = wl; v.rv = rv; v.ra = ra; v.rl = rl; v.dr = dr;
      v.e_av = av; v.e_at = at; v.e_aa = aa; v.e_wr = wr; v.e_rr = rr;
      v.e_wo = wo; v.e_ro = ro; v.e_err = er;
      return v;
   endfunction

   initial begin
      int ngr;
      rst = 1'b1;
      idle_inputs();

      // Vector table: inputs sampled at edge i, expected values after edge i.
      //              wv    wa             wl    rv    ra             rl    dr     av    at    aa             wr    rr    wo    ro    err
      vecs[0]  = mk(1'b1, 32'h0040_0800, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0040_0800, 1'b1, 1'b0, 3'd1, 3'd0, 1'b0);
      vecs[1]  = mk(1'b1, 32'h0040_0800, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b0, 1'b1, 32'h0040_0800, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0);
      vecs[2]  = mk(1'b1, 32'h0040_0C00, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0040_0C00, 1'b1, 1'b0, 3'd2, 3'd0, 1'b0);
      vecs[3]  = mk(1'b1, 32'h0040_0C00, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b0, 1'b1, 32'h0040_0C00, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0);
      vecs[4]  = mk(1'b1, 32'h0040_1000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b0, 1'b1, 32'h0040_0C00, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0);
      vecs[5]  = mk(1'b1, 32'h0040_1000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b0, 1'b1, 32'h0040_0C00, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0);
      vecs[6]  = mk(1'b1, 32'h0040_1000, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1,  1'b0, 1'b1, 32'h0040_0C00, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0);
      vecs[7]  = mk(1'b1, 32'h0040_1000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0040_1000, 1'b1, 1'b0, 3'd2, 3'd0, 1'b0);
      vecs[8]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b0, 1'b1, 32'h0040_1000, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0);
      vecs[9]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h1000_0000, 1'b0, 1'b1,  1'b1, 1'b0, 32'h1000_0000, 1'b0, 1'b1, 3'd2, 3'd1, 1'b0);
      vecs[10] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h1000_0000, 1'b0, 1'b1,  1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 3'd2, 3'd1, 1'b0);
      vecs[11] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h1000_0800, 1'b1, 1'b1,  1'b1, 1'b0, 32'h1000_0800, 1'b0, 1'b1, 3'd2, 3'd1, 1'b0);
      vecs[12] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b0, 1'b0, 32'h1000_0800, 1'b0, 1'b0, 3'd2, 3'd1, 1'b0);
      vecs[13] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1,  1'b0, 1'b0, 32'h1000_0800, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0);
      vecs[14] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1,  1'b0, 1'b0, 32'h1000_0800, 1'b0, 1'b0, 3'd2, 3'd0, 1'b1);
      vecs[15] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b0, 1'b0, 32'h1000_0800, 1'b0, 1'b0, 3'd2, 3'd0, 1'b1);

      exp_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 64; i++) begin
         lb_wr[i] = 1'b0;
         lb_rd[i] = 1'b0;
      end

      // Reset state (rst still held).
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 64'(outs()), 64'd0);
      check("reset_alen", 64'(bus.ddr_alen), 64'd31);
      rst = 1'b0;

      // Table-driven vectors.
      for (int i = 0; i < NV; i++) begin
         bus.wr_avalid    = vecs[i].wv;
         bus.wr_addr      = vecs[i].wa;
         bus.wr_last_beat = vecs[i].wl;
         bus.rd_avalid    = vecs[i].rv;
         bus.rd_addr      = vecs[i].ra;
         bus.rd_last_beat = vecs[i].rl;
         bus.ddr_aready   = vecs[i].dr;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), 64'(outs()),
               64'({vecs[i].e_av, vecs[i].e_at, vecs[i].e_aa, vecs[i].e_wr, vecs[i].e_rr,
                    vecs[i].e_wo, vecs[i].e_ro, vecs[i].e_err}));
         @(negedge clk);
      end
      check("alen_const", 64'(bus.ddr_alen), 64'd31);

      // Contention: both held, last_beat two cycles after each grant.
      do_reset();
      bus.wr_avalid  = 1'b1;
      bus.wr_addr    = 32'h0050_0000;
      bus.rd_avalid  = 1'b1;
      bus.rd_addr    = 32'h0060_0000;
      bus.ddr_aready = 1'b1;
      ngr = 0;
      for (int c = 0; c < 40 && ngr < 8; c++) begin
         bus.wr_last_beat = lb_wr[c];
         bus.rd_last_beat = lb_rd[c];
         @(posedge clk);
         #1;
         if (bus.wr_aready || bus.rd_aready) begin
            check($sformatf("contention_grant%0d", ngr),
                  64'({bus.wr_aready, bus.rd_aready, bus.ddr_atype}),
                  64'({exp_w[ngr], ~exp_w[ngr], exp_w[ngr]}));
            if (bus.wr_aready) lb_wr[c + 2] = 1'b1;
            else lb_rd[c + 2] = 1'b1;
            ngr++;
         end
         @(negedge clk);
      end
      check("contention_count", 64'(ngr), 64'd8);
      idle_inputs();

      // Backpressure: read granted, DDR stalls 5 cycles, write waits.
      do_reset();
      bus.rd_avalid = 1'b1;
      bus.rd_addr   = 32'hABCD_0000;
      @(posedge clk);
      #1;
      check("bp_grant", 64'({bus.ddr_avalid, bus.rd_aready, bus.ddr_atype, bus.ddr_aaddr}),
            64'({1'b1, 1'b1, 1'b0, 32'hABCD_0000}));
      @(negedge clk);
      bus.rd_avalid = 1'b0;
      bus.wr_avalid = 1'b1;
      bus.wr_addr   = 32'h0070_0000;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_hold%0d", k),
               64'({bus.ddr_avalid, bus.ddr_atype, bus.ddr_aaddr, bus.wr_aready, bus.rd_aready}),
               64'({1'b1, 1'b0, 32'hABCD_0000, 1'b0, 1'b0}));
         @(negedge clk);
      end
      bus.ddr_aready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_accept", 64'({bus.ddr_avalid, bus.wr_aready}), 64'({1'b0, 1'b0}));
      @(negedge clk);
      @(posedge clk);
      #1;
      check("bp_next_grant",
            64'({bus.ddr_avalid, bus.ddr_atype, bus.ddr_aaddr, bus.wr_aready,
                 bus.wr_outstanding, bus.rd_outstanding}),
            64'({1'b1, 1'b1, 32'h0070_0000, 1'b1, 3'd1, 3'd1}));

      // Async reset mid-ISSUE: outputs clear before the next clock edge.
      #1;
      rst = 1'b1;
      #1;
      check("async_reset",
            64'({bus.ddr_avalid, bus.wr_aready, bus.rd_aready,
                 bus.wr_outstanding, bus.rd_outstanding, bus.cnt_err}),
            64'd0);
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
